// File: rtl/sincos_nco.sv
// sincos_nco: pipelined, stream-handshaked sin/cos generator with direct-angle and NCO modes.
// Optional macro SINCOS_PHASE_TAG_EN adds out_angle, the angle that produced each result.

module sincos_nco_lane #(
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [15:0]             x,
  output logic signed [OUT_W-1:0] r
);
  function automatic logic [15:0] hm(input logic signed [15:0] a,
                                     input logic signed [15:0] b,
                                     input logic [15:0]        c);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return 16'(p >>> 16) + c;
  endfunction

  logic [2:0]         n1, n2;
  logic signed [15:0] y1, z1, y2, z2, sumc2, sum1_2, sa3;
  logic               neg3;
  logic [15:0]        y0, sums, cc, sa_d;
  logic signed [31:0] prod;
  logic signed [15:0] r16;
  logic signed [OUT_W-1:0] rn;

  assign y0   = {x[13:0], 2'b00};
  assign sums = hm(z1, 16'h04F8, -16'h2953);
  // Odd octant pairs use the cosine polynomial offset from full scale.
  assign prod = n2[1] ? 32'(z2) * 32'(sumc2) : 32'(y2) * 32'(sum1_2);
  assign cc   = 16'(prod >>> 15);
  assign sa_d = n2[1] ? cc + 16'h7FFF : cc;
  assign r16  = neg3 ? -sa3 : sa3;

  generate
    if (OUT_W == 16) begin : g_full
      assign rn = r16;
    end else begin : g_round
      localparam int MAXV = (1 << (OUT_W-1)) - 1;
      int v;
      always_comb begin
        v  = (int'(r16) + (1 << (15-OUT_W))) >>> (16-OUT_W);
        rn = OUT_W'(v);
        if (v > MAXV)       rn = OUT_W'(MAXV);
        else if (v < -MAXV) rn = OUT_W'(-MAXV);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      n1 <= '0; y1 <= '0; z1 <= '0;
      n2 <= '0; y2 <= '0; z2 <= '0; sumc2 <= '0; sum1_2 <= '0;
      neg3 <= 1'b0; sa3 <= '0;
      r <= '0;
    end else if (en) begin
      n1     <= x[15:13] + 3'd1;
      y1     <= y0;
      z1     <= hm(y0, y0, 16'h0000);
      n2     <= n1;
      y2     <= y1;
      z2     <= z1;
      sumc2  <= hm(z1, 16'h0FBD, -16'h4EE9);
      sum1_2 <= hm(z1, sums, 16'h6487);
      neg3   <= n2[2];
      sa3    <= sa_d;
      r      <= rn;
    end
  end
endmodule

module sincos_nco #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             angle,
  input  logic [PHASE_W-1:0]      freq,
  input  logic                    phase_ld,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] sin_out,
  output logic signed [OUT_W-1:0] cos_out
`ifdef SINCOS_PHASE_TAG_EN
  ,
  output logic [15:0]             out_angle
`endif
);
  localparam int STAGES = 4;

  logic                    en, xfer, nco;
  logic [STAGES:1]         vld_pipe;
  logic [PHASE_W-1:0]      acc, acc_base;
  logic [15:0]             ang;
  logic [1:0][15:0]        lane_x;
  logic [1:0][OUT_W-1:0]   lane_r;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign xfer      = in_valid && en;
  assign nco       = xfer && mode;
  // A same-cycle phase load wins over the accumulator for the sample angle.
  assign ang       = (mode && !phase_ld) ? acc[PHASE_W-1 -: 16] : angle;
  assign acc_base  = phase_ld ? (PHASE_W'(angle) << (PHASE_W-16)) : acc;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst)                  acc <= '0;
    else if (phase_ld || nco) acc <= acc_base + (nco ? freq : '0);
  end

  always_ff @(posedge clk) begin
    if (rst)     vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
  end

  assign lane_x[0] = ang;
  assign lane_x[1] = ang + 16'h4000;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    sincos_nco_lane #(.OUT_W(OUT_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .x   (lane_x[i]),
      .r   (lane_r[i])
    );
  end

  assign sin_out = lane_r[0];
  assign cos_out = lane_r[1];

`ifdef SINCOS_PHASE_TAG_EN
  logic [STAGES:1][15:0] tag_pipe;

  always_ff @(posedge clk) begin
    if (rst)     tag_pipe <= '0;
    else if (en) tag_pipe <= {tag_pipe[STAGES-1:1], ang};
  end

  assign out_angle = tag_pipe[STAGES];
`else
  // Without the tag the sample angle feeds only the lanes.
`endif
endmodule

// File: tb/tb_sincos_nco.sv
// Directed, table-driven bench for sincos_nco: a 16-bit and a 12-bit instance share stimulus.
module tb_sincos_nco;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst, mode, in_valid, phase_ld, out_ready;
  logic in_ready, in_ready12, out_valid, out_valid12;
  logic [15:0] angle;
  logic [PW-1:0] freq;
  logic signed [15:0] sin_out, cos_out;
  logic signed [11:0] sin12, cos12;
`ifdef SINCOS_PHASE_TAG_EN
  logic [15:0] out_angle, out_angle12;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] ang;
    int s16, c16, s12, c12;
  } vec_t;
  typedef struct { int s, c; } smp_t;

  vec_t tv[7];
  smp_t q[$];
  int   es[$], ec[$];

  always #5 clk = ~clk;

  sincos_nco #(.PHASE_W(PW), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .angle(angle), .freq(freq), .phase_ld(phase_ld), .out_valid(out_valid),
    .out_ready(out_ready), .sin_out(sin_out), .cos_out(cos_out)
`ifdef SINCOS_PHASE_TAG_EN
    , .out_angle(out_angle)
`endif
  );

  sincos_nco #(.PHASE_W(PW), .OUT_W(12)) dut12 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready12),
    .angle(angle), .freq(freq), .phase_ld(phase_ld), .out_valid(out_valid12),
    .out_ready(out_ready), .sin_out(sin12), .cos_out(cos12)
`ifdef SINCOS_PHASE_TAG_EN
    , .out_angle(out_angle12)
`endif
  );

  // Accepted results of the 16-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back('{int'(sin_out), int'(cos_out)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_q(input string nm);
    chk({nm, "_count"}, q.size(), es.size());
    for (int i = 0; i < es.size(); i++) begin
      chk({nm, "_sin"}, (i < q.size()) ? q[i].s : -999999, es[i]);
      chk({nm, "_cos"}, (i < q.size()) ? q[i].c : -999999, ec[i]);
    end
  endtask

  initial begin
    int sent, psin, pcos;
    tv[0] = '{16'h0000,      0,  32767,     0,  2047};
    tv[1] = '{16'h4000,  32767,      0,  2047,     0};
    tv[2] = '{16'h8000,      0, -32767,     0, -2047};
    tv[3] = '{16'hC000, -32767,      0, -2047,     0};
    tv[4] = '{16'h2000,  23170,  23169,  1448,  1448};
    tv[5] = '{16'h1000,  12539,  30273,   784,  1892};
    tv[6] = '{16'hF000, -12539,  30273,  -784,  1892};

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; angle = '0; freq = '0;
    phase_ld = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sin", int'(sin_out), 0);
    chk("reset_cos", int'(cos_out), 0);
    chk("reset_in_ready", int'(in_ready), 1);

    // Direct mode: latency 4, one result per cycle, both widths.
    for (int c = 0; c < 7 + 3; c++) begin
      in_valid = (c < 7);
      angle    = tv[(c < 7) ? c : 0].ang;
      step();
      if (c >= 3) begin
        chk("dir_valid", int'(out_valid), 1);
        chk("dir_sin16", int'(sin_out), tv[c-3].s16);
        chk("dir_cos16", int'(cos_out), tv[c-3].c16);
        chk("dir_sin12", int'(sin12), tv[c-3].s12);
        chk("dir_cos12", int'(cos12), tv[c-3].c12);
`ifdef SINCOS_PHASE_TAG_EN
        chk("dir_tag", int'(out_angle), int'(tv[c-3].ang));
`endif
      end else begin
        chk("dir_latency", int'(out_valid), 0);
      end
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Backpressure: 8 samples, out_ready low for 3 cycles mid-stream.
    q.delete();
    sent = 0; psin = 0; pcos = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (sent < 8);
      angle     = tv[sent % 7].ang;
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_valid", int'(out_valid), 1);
        if (cyc > 5) begin
          chk("stall_sin_hold", int'(sin_out), psin);
          chk("stall_cos_hold", int'(cos_out), pcos);
        end
      end
      psin = int'(sin_out);
      pcos = int'(cos_out);
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", sent, 8);
    es.delete(); ec.delete();
    for (int i = 0; i < 8; i++) begin
      es.push_back(tv[i % 7].s16);
      ec.push_back(tv[i % 7].c16);
    end
    check_q("bp");

    // NCO: load 0, quarter-turn steps, idle gaps must not advance the phase.
    phase_ld = 1'b1; angle = 16'h0000; freq = 32'h4000_0000;
    step();
    phase_ld = 1'b0; angle = 16'h1234;
    repeat (2) step();
    q.delete();
    mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i != 2 && i != 3);
      step();
    end
    in_valid = 1'b0; mode = 1'b0;
    repeat (8) step();
    es = '{0, 32767, 0, -32767, 0};
    ec = '{32767, 0, -32767, 0, 32767};
    check_q("nco");

    // Load coinciding with an NCO transfer: the load value is used and stepped.
    q.delete();
    phase_ld = 1'b1; in_valid = 1'b1; mode = 1'b1; angle = 16'h4000;
    step();
    phase_ld = 1'b0; angle = 16'h0000;
    repeat (2) step();
    in_valid = 1'b0; mode = 1'b0;
    repeat (8) step();
    es = '{32767, 0, -32767};
    ec = '{0, -32767, 0};
    check_q("ld_xfer");

    // Reset with 3 samples in flight and a nonzero accumulator.
    phase_ld = 1'b1; angle = 16'h4000;
    step();
    phase_ld = 1'b0; in_valid = 1'b1; mode = 1'b0;
    repeat (3) step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("rst_flush_valid", int'(out_valid), 0);
    chk("rst_flush_valid12", int'(out_valid12), 0);
    rst = 1'b0;
    q.delete();
    repeat (8) step();
    chk("rst_no_stale", q.size(), 0);
    mode = 1'b1; in_valid = 1'b1; freq = 32'h4000_0000;
    step();
    in_valid = 1'b0; mode = 1'b0;
    repeat (8) step();
    es = '{0};
    ec = '{32767};
    check_q("rst_acc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
